mcdf_arbiter: RTL and testbench
===============================

Name: mcdf_arbiter

Overview:
- Selects one of three slave channels and streams a whole packet from it to the formatter.
- Sits between the per-channel slave FIFOs and the formatter in the MCDF datapath.
- Drives the formatter's a2f_* inputs and consumes f2a_ack and the formatter's id request.
- Arbitration uses the per-channel priority from the register block; priority ties are broken round-robin.

Parameters:
- DW, 32, data width of the slave and formatter data buses.
- CNT_W, 6, width of the beat counter; must hold a count of 32.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous reset, active-low.
- slv0_val_i / slv1_val_i / slv2_val_i  in  1 each  channel has a data word available.
- slv0_data_i / slv1_data_i / slv2_data_i  in  DW each  channel head-of-FIFO data.
- slv0_prio_i / slv1_prio_i / slv2_prio_i  in  2 each  channel priority; 0 is highest.
- slv0_pkglen_i / slv1_pkglen_i / slv2_pkglen_i  in  3 each  channel packet-length select.
- slv0_ack_o / slv1_ack_o / slv2_ack_o  out  1 each  pop strobe to the channel FIFO.
- f2a_id_req_i  in  1  formatter is ready to start a new packet.
- f2a_ack_i  in  1  formatter accepts the current beat.
- a2f_val_o  out  1  beat valid.
- a2f_id_o  out  2  granted channel; 2'b11 means idle.
- a2f_data_o  out  DW  beat data.
- a2f_pkglen_sel_o  out  3  packet-length select of the granted channel.
- a2f_end_o  out  1  marks the last beat of the packet.

Behaviour:
- Reset (async, rstn_i low):
  - state=IDLE, a2f_id_o=2'b11, a2f_pkglen_sel_o=0, beat counter=0.
  - rr_last=2 (channel 0 wins the first tie).
  - All val/ack/end outputs 0; a2f_data_o=0.
- Reset asserted mid-packet aborts the packet immediately: no a2f_end_o, and the FIFOs receive no further acks.
- Packet length L from pkglen: 0→4, 1→8, 2→16, 3..7→32 beats.
- State IDLE:
  - If f2a_id_req_i=1 and any slvN_val_i=1, the winner is registered and the block moves to XFER on the next edge.
  - Otherwise it stays in IDLE.
- Winner selection:
  - Lowest prio value among valid channels wins.
  - On a tie, the first tied channel after rr_last in the order 0→1→2→0 wins.
- On grant:
  - a2f_id_o is set to the winner and a2f_pkglen_sel_o to that channel's pkglen.
  - L is latched and the counter cleared; rr_last is set to the winner.
  - Grant latency is 1 cycle from the sampled request.
- State XFER:
  - a2f_val_o = slvG_val_i and a2f_data_o = slvG_data_i, combinational from the granted channel G.
  - A beat occurs when a2f_val_o & f2a_ack_i; slvG_ack_o is asserted in that same cycle. All other ack outputs stay 0.
  - Each beat increments the counter.
  - a2f_end_o = beat & (counter==L-1), combinational.
  - After the end beat: next edge returns to IDLE with a2f_id_o=2'b11, counter=0 and a2f_data_o=0.
- Stall: if slvG_val_i drops mid-packet, the grant is held and no beat occurs. There is no timeout.
- While in XFER, f2a_id_req_i and requests from other channels are ignored.
- Changes to prio or pkglen inputs mid-packet have no effect on the current packet.
- At least one IDLE cycle separates consecutive packets.
- f2a_ack_i while a2f_val_o=0 is ignored.

Optional Feature:
- Macro MCDF_ARB_STAT_EN.
- Defined:
  - Adds outputs stat0_pkts_o, stat1_pkts_o, stat2_pkts_o, each 16 bits.
  - Each counts completed packets (end beats) per channel and wraps 0xFFFF→0.
  - Counters reset to 0 asynchronously.
  - A packet aborted by reset is not counted.
- Undefined: no statistics ports or logic; all other behaviour is identical.

Test Plan:
- Single channel, len 4:
  - Stimulus: ch1 val=1, pkglen=0, id_req pulse, f2a_ack=1 continuously.
  - Response: a2f_id=01 from the next cycle; 4 beats; slv1_ack high 4 cycles; a2f_end on beat 4; then id=11.
- Priority:
  - Stimulus: ch0 prio=2, ch2 prio=1, both valid, id_req.
  - Response: grant ch2 (id=10), pkglen_sel = ch2 value.
- Round-robin:
  - Stimulus: all prio=0, all valid, four consecutive packets.
  - Response: grants in order 0, 1, 2, 0.
- Stall:
  - Stimulus: ch0 len 8; slv0_val low for 3 cycles after beat 2.
  - Response: id held at 00; no ack during the stall; 8 beats total; a2f_end on beat 8.
- Reset mid-packet:
  - Stimulus: rstn_i low after beat 5 of a 16-beat packet.
  - Response: outputs go to reset values immediately; no a2f_end.
  - With MCDF_ARB_STAT_EN: the stat counter is unchanged.
- Mid-packet pkglen change:
  - Stimulus: ch1 pkglen 1→3 after beat 2.
  - Response: packet still ends at beat 8; a2f_pkglen_sel stays 1.

Source files
------------

// File: rtl/mcdf_arbiter.sv
// mcdf_arbiter: picks one of three slave channels by priority (round-robin on ties) and streams a whole packet to the formatter; define MCDF_ARB_STAT_EN for per-channel packet counters
module mcdf_arbiter #(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          slv0_val_i,
    input  logic          slv1_val_i,
    input  logic          slv2_val_i,
    input  logic [DW-1:0] slv0_data_i,
    input  logic [DW-1:0] slv1_data_i,
    input  logic [DW-1:0] slv2_data_i,
    input  logic [1:0]    slv0_prio_i,
    input  logic [1:0]    slv1_prio_i,
    input  logic [1:0]    slv2_prio_i,
    input  logic [2:0]    slv0_pkglen_i,
    input  logic [2:0]    slv1_pkglen_i,
    input  logic [2:0]    slv2_pkglen_i,
    output logic          slv0_ack_o,
    output logic          slv1_ack_o,
    output logic          slv2_ack_o,
    input  logic          f2a_id_req_i,
    input  logic          f2a_ack_i,
`ifdef MCDF_ARB_STAT_EN
    output logic [15:0]   stat0_pkts_o,
    output logic [15:0]   stat1_pkts_o,
    output logic [15:0]   stat2_pkts_o,
`endif
    output logic          a2f_val_o,
    output logic [1:0]    a2f_id_o,
    output logic [DW-1:0] a2f_data_o,
    output logic [2:0]    a2f_pkglen_sel_o,
    output logic          a2f_end_o
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t state, state_nx;

    // Entry 3 is a dummy channel so a 2-bit id can index without range issues
    logic [3:0]       v;
    logic [DW-1:0]    d  [4];
    logic [1:0]       p  [4];
    logic [2:0]       pl [4];
    logic [1:0]       gnt, rr_last, win, min_p, c;
    logic [CNT_W-1:0] cnt, len;
    logic [2:0]       ack;
    logic             grant, beat, last;

    assign v     = {1'b0, slv2_val_i, slv1_val_i, slv0_val_i};
    assign d[0]  = slv0_data_i;
    assign d[1]  = slv1_data_i;
    assign d[2]  = slv2_data_i;
    assign d[3]  = '0;
    assign p[0]  = slv0_prio_i;
    assign p[1]  = slv1_prio_i;
    assign p[2]  = slv2_prio_i;
    assign p[3]  = 2'd3;
    assign pl[0] = slv0_pkglen_i;
    assign pl[1] = slv1_pkglen_i;
    assign pl[2] = slv2_pkglen_i;
    assign pl[3] = 3'd0;

    assign grant      = (state == IDLE) && f2a_id_req_i && (|v[2:0]);
    assign a2f_id_o   = gnt;
    assign a2f_end_o  = last;
    assign slv0_ack_o = ack[0];
    assign slv1_ack_o = ack[1];
    assign slv2_ack_o = ack[2];

    function automatic logic [CNT_W-1:0] len_of(input logic [2:0] sel);
        return sel == 3'd0 ? CNT_W'(4) : sel == 3'd1 ? CNT_W'(8) : sel == 3'd2 ? CNT_W'(16) : CNT_W'(32);
    endfunction

    // Winner: lowest prio among valid channels; scanning the rr order backwards leaves the first tied channel after rr_last
    always_comb begin
        min_p = 2'd3;
        win   = 2'd0;
        c     = 2'd0;
        for (int i = 0; i < 3; i++)
            if (v[i] && p[i] < min_p) min_p = p[i];
        for (int k = 3; k >= 1; k--) begin
            c = 2'((int'(rr_last) + k) % 3);
            if (v[c] && p[c] == min_p) win = c;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) state <= IDLE;
        else         state <= state_nx;

    // Next state and beat-level outputs, all combinational from the granted channel
    always_comb begin
        state_nx   = state;
        a2f_val_o  = 1'b0;
        a2f_data_o = '0;
        beat       = 1'b0;
        last       = 1'b0;
        ack        = 3'b000;
        if (state == XFER) begin
            a2f_val_o  = v[gnt];
            a2f_data_o = d[gnt];
            beat       = a2f_val_o & f2a_ack_i;
            ack        = {2'b00, beat} << gnt;
            last       = beat && (cnt == len - 1'b1);
            state_nx   = last ? IDLE : XFER;
        end else begin
            state_nx   = grant ? XFER : IDLE;
        end
    end

    // Grant bookkeeping and beat counter; prio/pkglen are only sampled at grant time
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            gnt              <= 2'd3;
            a2f_pkglen_sel_o <= 3'd0;
            len              <= '0;
            cnt              <= '0;
            rr_last          <= 2'd2;
        end else if (grant) begin
            gnt              <= win;
            a2f_pkglen_sel_o <= pl[win];
            len              <= len_of(pl[win]);
            cnt              <= '0;
            rr_last          <= win;
        end else if (last) begin
            gnt              <= 2'd3;
            cnt              <= '0;
        end else if (beat) begin
            cnt              <= cnt + 1'b1;
        end

`ifdef MCDF_ARB_STAT_EN
    // Completed-packet counters, bumped on each channel's end beat and wrapping naturally
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            stat0_pkts_o <= '0;
            stat1_pkts_o <= '0;
            stat2_pkts_o <= '0;
        end else begin
            if (last && ack[0]) stat0_pkts_o <= stat0_pkts_o + 1'b1;
            if (last && ack[1]) stat1_pkts_o <= stat1_pkts_o + 1'b1;
            if (last && ack[2]) stat2_pkts_o <= stat2_pkts_o + 1'b1;
        end
`endif

endmodule

// File: tb/tb_mcdf_arbiter.sv
// tb_mcdf_arbiter: per-cycle vector table plus multi-cycle packet sequences for mcdf_arbiter
module tb_mcdf_arbiter;

    localparam int DW = 32;

    typedef struct {
        logic       rst;
        logic [2:0] val;
        logic       req;
        logic       ack;
        logic [5:0] prio;
        logic [8:0] plen;
        logic [1:0] e_id;
        logic       e_val;
        logic [2:0] e_sack;
        logic       e_end;
        logic [2:0] e_psel;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic [2:0]    val_v;
    logic [1:0]    pr  [3];
    logic [2:0]    pl  [3];
    logic [DW-1:0] dat [3];
    logic          id_req, f_ack;
    logic [2:0]    sack;
    logic          a2f_val, a2f_end;
    logic [1:0]    a2f_id;
    logic [DW-1:0] a2f_data;
    logic [2:0]    a2f_psel;
`ifdef MCDF_ARB_STAT_EN
    logic [15:0]   st0, st1, st2;
`endif

    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    mcdf_arbiter #(.DW(DW), .CNT_W(6)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn_i),
        .slv0_val_i       (val_v[0]),
        .slv1_val_i       (val_v[1]),
        .slv2_val_i       (val_v[2]),
        .slv0_data_i      (dat[0]),
        .slv1_data_i      (dat[1]),
        .slv2_data_i      (dat[2]),
        .slv0_prio_i      (pr[0]),
        .slv1_prio_i      (pr[1]),
        .slv2_prio_i      (pr[2]),
        .slv0_pkglen_i    (pl[0]),
        .slv1_pkglen_i    (pl[1]),
        .slv2_pkglen_i    (pl[2]),
        .slv0_ack_o       (sack[0]),
        .slv1_ack_o       (sack[1]),
        .slv2_ack_o       (sack[2]),
        .f2a_id_req_i     (id_req),
        .f2a_ack_i        (f_ack),
`ifdef MCDF_ARB_STAT_EN
        .stat0_pkts_o     (st0),
        .stat1_pkts_o     (st1),
        .stat2_pkts_o     (st2),
`endif
        .a2f_val_o        (a2f_val),
        .a2f_id_o         (a2f_id),
        .a2f_data_o       (a2f_data),
        .a2f_pkglen_sel_o (a2f_psel),
        .a2f_end_o        (a2f_end)
    );

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [2:0] val, input logic req, input logic ack,
                       input logic [5:0] prio, input logic [8:0] plen, input logic [1:0] e_id,
                       input logic e_val, input logic [2:0] e_sack, input logic e_end, input logic [2:0] e_psel);
        vq.push_back('{rst, val, req, ack, prio, plen, e_id, e_val, e_sack, e_end, e_psel});
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        @(posedge clk);
        #1;
        rstn_i = 1'b1;
    endtask

    // One packet on channel ch with f2a_ack held high; optional stall, pkglen change or reset keyed to a beat count
    task automatic xfer(input int ch, input int stall_at, input int chg_at, input int rst_at,
                        input logic [2:0] exp_psel, output int beats, output int end_at);
        int  stall = 0;
        int  misc  = 0;
        bit  done  = 0;
        bit  rst_seen = 0;
        beats  = 0;
        end_at = 0;
        val_v  = 3'b000;
        val_v[ch] = 1'b1;
        id_req = 1'b1;
        f_ack  = 1'b1;
        @(negedge clk);
        chk("req_idle_id", ch, 32'(a2f_id), 32'd3);
        @(posedge clk);
        #1;
        id_req = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            val_v[ch] = !(beats == stall_at && stall < 3);
            if (beats == chg_at) pl[ch] = 3'd3;
            if (beats == rst_at) rstn_i = 1'b0;
            @(negedge clk);
            if (!rstn_i) begin
                done = 1;
                rst_seen = 1;
                chk("rst_id", ch, 32'(a2f_id), 32'd3);
                chk("rst_val", ch, 32'(a2f_val), 32'd0);
                chk("rst_sack", ch, 32'(sack), 32'd0);
                chk("rst_end", ch, 32'(a2f_end), 32'd0);
                chk("rst_data", ch, a2f_data, 32'd0);
                chk("rst_psel", ch, 32'(a2f_psel), 32'd0);
            end else begin
                if (a2f_id != 2'(ch) || a2f_psel != exp_psel) misc++;
                if (a2f_val != val_v[ch]) misc++;
                if (sack != (val_v[ch] ? 3'(1 << ch) : 3'b000)) misc++;
                if (a2f_data != dat[ch]) misc++;
                if (a2f_end && !sack[ch]) misc++;
                if (sack[ch]) begin
                    beats++;
                    if (a2f_end) begin
                        end_at = beats;
                        done = 1;
                    end
                end else if (beats == stall_at) stall++;
            end
            @(posedge clk);
            #1;
        end
        chk("pkt_misc", ch, 32'(misc), 32'd0);
        chk("pkt_done", ch, 32'(done), 32'd1);
        if (rst_seen) begin
            rstn_i = 1'b1;
        end else begin
            val_v = 3'b000;
            @(negedge clk);
            chk("post_id", ch, 32'(a2f_id), 32'd3);
            chk("post_val", ch, 32'(a2f_val), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        localparam logic [5:0] PR_P = 6'b01_00_10;
        localparam logic [8:0] PL_P = 9'b010_000_101;
        int         beats, end_at;
        logic [1:0] w;
        logic [DW-1:0] ed;
        rstn_i = 1'b0;
        val_v  = 3'b000;
        id_req = 1'b0;
        f_ack  = 1'b0;
        dat[0] = 32'hA0A0_0001;
        dat[1] = 32'hB1B1_0002;
        dat[2] = 32'hC2C2_0003;
        for (int i = 0; i < 3; i++) begin
            pr[i] = 2'd0;
            pl[i] = 3'd0;
        end

        // reset, then single channel 1 packet of 4 beats
        add(1, 3'b000, 0, 0, 6'd0, 9'd0, 2'd3, 0, 3'b000, 0, 3'd0);
        add(0, 3'b010, 1, 1, 6'd0, 9'd0, 2'd3, 0, 3'b000, 0, 3'd0);
        add(0, 3'b010, 0, 1, 6'd0, 9'd0, 2'd1, 1, 3'b010, 0, 3'd0);
        add(0, 3'b010, 0, 1, 6'd0, 9'd0, 2'd1, 1, 3'b010, 0, 3'd0);
        add(0, 3'b010, 0, 1, 6'd0, 9'd0, 2'd1, 1, 3'b010, 0, 3'd0);
        add(0, 3'b010, 0, 1, 6'd0, 9'd0, 2'd1, 1, 3'b010, 1, 3'd0);
        add(0, 3'b010, 0, 1, 6'd0, 9'd0, 2'd3, 0, 3'b000, 0, 3'd0);
        // id_req with nothing valid stays idle
        add(0, 3'b000, 1, 1, 6'd0, 9'd0, 2'd3, 0, 3'b000, 0, 3'd0);
        add(0, 3'b000, 1, 1, 6'd0, 9'd0, 2'd3, 0, 3'b000, 0, 3'd0);
        // priority: ch2 (prio 1) beats ch0 (prio 2) although rr would pick ch0
        add(1, 3'b000, 0, 0, PR_P, PL_P, 2'd3, 0, 3'b000, 0, 3'd0);
        add(0, 3'b101, 1, 0, PR_P, PL_P, 2'd3, 0, 3'b000, 0, 3'd0);
        add(0, 3'b101, 0, 0, PR_P, PL_P, 2'd2, 1, 3'b000, 0, 3'd2);
        add(0, 3'b101, 0, 1, PR_P, PL_P, 2'd2, 1, 3'b100, 0, 3'd2);
        add(1, 3'b101, 0, 1, PR_P, PL_P, 2'd3, 0, 3'b000, 0, 3'd0);
        // round-robin among equal priorities: 0, 1, 2, 0; id_req stays high and is ignored in XFER
        for (int r = 0; r < 4; r++) begin
            w = 2'(r % 3);
            add(0, 3'b111, 1, 1, 6'd0, 9'd0, 2'd3, 0, 3'b000, 0, 3'd0);
            for (int b = 0; b < 4; b++)
                add(0, 3'b111, 1, 1, 6'd0, 9'd0, w, 1, 3'(1 << w), b == 3, 3'd0);
        end
        add(0, 3'b000, 0, 0, 6'd0, 9'd0, 2'd3, 0, 3'b000, 0, 3'd0);

        @(posedge clk);
        #1;
        foreach (vq[n]) begin
            rstn_i = !vq[n].rst;
            val_v  = vq[n].val;
            id_req = vq[n].req;
            f_ack  = vq[n].ack;
            for (int i = 0; i < 3; i++) begin
                pr[i] = vq[n].prio[2*i +: 2];
                pl[i] = vq[n].plen[3*i +: 3];
            end
            ed = (vq[n].e_id == 2'd3) ? '0 : dat[vq[n].e_id];
            @(negedge clk);
            chk("id", n, 32'(a2f_id), 32'(vq[n].e_id));
            chk("val", n, 32'(a2f_val), 32'(vq[n].e_val));
            chk("sack", n, 32'(sack), 32'(vq[n].e_sack));
            chk("end", n, 32'(a2f_end), 32'(vq[n].e_end));
            chk("psel", n, 32'(a2f_psel), 32'(vq[n].e_psel));
            chk("data", n, a2f_data, ed);
            @(posedge clk);
            #1;
        end

        do_reset();
        for (int i = 0; i < 3; i++) begin
            pr[i] = 2'd0;
            pl[i] = 3'd1;
        end
        // stall: ch0 len 8, val low 3 cycles after beat 2
        xfer(0, 2, -1, -1, 3'd1, beats, end_at);
        chk("stall_beats", 0, 32'(beats), 32'd8);
        chk("stall_end", 0, 32'(end_at), 32'd8);
        // mid-packet pkglen change on ch1 has no effect
        xfer(1, -1, 2, -1, 3'd1, beats, end_at);
        chk("chg_beats", 1, 32'(beats), 32'd8);
        chk("chg_end", 1, 32'(end_at), 32'd8);
        // pkglen 5 maps to 32 beats
        pl[0] = 3'd5;
        xfer(0, -1, -1, -1, 3'd5, beats, end_at);
        chk("len32_end", 0, 32'(end_at), 32'd32);
`ifdef MCDF_ARB_STAT_EN
        chk("stat0", 0, 32'(st0), 32'd2);
        chk("stat1", 1, 32'(st1), 32'd1);
        chk("stat2", 2, 32'(st2), 32'd0);
`endif
        // reset after beat 5 of a 16-beat packet aborts it without an end beat
        pl[2] = 3'd2;
        xfer(2, -1, -1, 5, 3'd2, beats, end_at);
        chk("abort_beats", 2, 32'(beats), 32'd5);
        chk("abort_end", 2, 32'(end_at), 32'd0);
`ifdef MCDF_ARB_STAT_EN
        chk("stat2_abort", 2, 32'(st2), 32'd0);
`endif
        // full 16-beat packet on ch2
        xfer(2, -1, -1, -1, 3'd2, beats, end_at);
        chk("len16_end", 2, 32'(end_at), 32'd16);
`ifdef MCDF_ARB_STAT_EN
        chk("stat2_done", 2, 32'(st2), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
